// File: rtl/bcd4_to_bin_seq_pkg.sv
// Shared definitions for the sequential 4-digit BCD -> binary converter:
// FSM encoding, BCD field geometry and a digit-validity helper.
package bcd4_to_bin_seq_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // True when every nibble of the packed BCD word is a decimal digit (0..9).
  function automatic logic digits_valid(input logic [BCD_W-1:0] bcd);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd4_to_bin_seq_nibble.sv
// Reverse double-dabble correction for one BCD nibble after a right shift:
// a nibble that reads >= 8 received a carried-in 10 (shows as 8) and drops 3.
module bcd_nibble_sub3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;

endmodule

// File: rtl/bcd4_to_bin_seq.sv
// Sequential 4-digit BCD -> binary converter: one shift-and-correct step per
// clock with a Start/Busy/Done handshake and an invalid-digit fast path.
module bcd4_to_bin_seq
  import bcd4_to_bin_seq_pkg::*;
#(
  parameter int OUTPUT_BIT_WIDTH = 14
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic [3:0]                  Digit3,
  input  logic [3:0]                  Digit2,
  input  logic [3:0]                  Digit1,
  input  logic [3:0]                  Digit0,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Error,
  output logic [OUTPUT_BIT_WIDTH-1:0] Output
);

  localparam int W     = OUTPUT_BIT_WIDTH;
  localparam int CNT_W = $clog2(W);
  localparam int SR_W  = BCD_W + W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [W-1:0]      out_q, out_d;

  logic [BCD_W-1:0]  bcd_in;
  logic [SR_W-1:0]   sr_shr;
  logic [SR_W-1:0]   sr_step;

  assign bcd_in = {Digit3, Digit2, Digit1, Digit0};

  // One datapath step: shift the whole {BCD,BIN} word right, then correct
  // each BCD nibble; the binary field just receives the shifted-out bits.
  assign sr_shr = sr_q >> 1;
  assign sr_step[W-1:0] = sr_shr[W-1:0];

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_nib
    bcd_nibble_sub3 u_nib (
      .nib_i (sr_shr [W + 4*g +: 4]),
      .nib_o (sr_step[W + 4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (digits_valid(bcd_in)) begin
            sr_d    = {bcd_in, {W{1'b0}}};
            cnt_d   = '0;
            error_d = 1'b0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end else begin
            // Clearing SR makes the DONE-edge output capture yield 0.
            sr_d    = '0;
            error_d = 1'b1;
            out_d   = '0;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        out_d   = sr_q[W-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      out_q   <= out_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Error  = error_q;
  assign Output = out_q;

endmodule

// File: tb/tb_bcd4_to_bin_seq.sv
// Directed bench for bcd4_to_bin_seq: vector table on a W=14 build, hand
// sequences for handshake corner cases, and a value sweep on a W=16 build.
module tb_bcd4_to_bin_seq;

  localparam int W14 = 14;
  localparam int W16 = 16;

  logic            clk;
  logic            rst;
  logic            start14, start16;
  logic [15:0]     dig14, dig16;
  logic            busy14, done14, err14;
  logic            busy16, done16, err16;
  logic [W14-1:0]  out14;
  logic [W16-1:0]  out16;

  int checks = 0;
  int errors = 0;

  bcd4_to_bin_seq #(.OUTPUT_BIT_WIDTH(W14)) dut14 (
    .Clk(clk), .Reset(rst), .Start(start14),
    .Digit3(dig14[15:12]), .Digit2(dig14[11:8]), .Digit1(dig14[7:4]), .Digit0(dig14[3:0]),
    .Busy(busy14), .Done(done14), .Error(err14), .Output(out14)
  );

  bcd4_to_bin_seq #(.OUTPUT_BIT_WIDTH(W16)) dut16 (
    .Clk(clk), .Reset(rst), .Start(start16),
    .Digit3(dig16[15:12]), .Digit2(dig16[11:8]), .Digit1(dig16[7:4]), .Digit0(dig16[3:0]),
    .Busy(busy16), .Done(done16), .Error(err16), .Output(out16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    int          exp_out;
    logic        exp_err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse Start on the W=14 instance and check latency, busy span, result.
  task automatic run14(input logic [15:0] bcd, input int exp_out, input logic exp_err);
    int edges, busy_n;
    logic seen;
    @(negedge clk); dig14 = bcd; start14 = 1'b1;
    @(negedge clk); start14 = 1'b0;
    edges = 1; busy_n = 0; seen = 1'b0;
    while (!seen && edges < 60) begin
      if (done14) seen = 1'b1;
      else begin
        if (busy14) busy_n++;
        @(negedge clk); edges++;
      end
    end
    chk($sformatf("done_seen %h", bcd), seen, 1);
    chk($sformatf("latency %h", bcd), edges, exp_err ? 2 : W14 + 2);
    chk($sformatf("busy_cycles %h", bcd), busy_n, exp_err ? 0 : W14 + 1);
    chk($sformatf("output %h", bcd), out14, exp_out);
    chk($sformatf("error %h", bcd), err14, exp_err);
    chk($sformatf("busy_at_done %h", bcd), busy14, 0);
    @(negedge clk);
    chk($sformatf("done_pulse %h", bcd), done14, 0);
  endtask

  task automatic run16(input logic [15:0] bcd, input int exp_out, input logic exp_err);
    int n;
    @(negedge clk); dig16 = bcd; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    n = 0;
    while (!done16 && n < 60) begin @(negedge clk); n++; end
    chk($sformatf("w16_done %h", bcd), done16, 1);
    chk($sformatf("w16_output %h", bcd), out16, exp_out);
    chk($sformatf("w16_error %h", bcd), err16, exp_err);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    b[15:12] = 4'((v / 1000) % 10);
    b[11:8]  = 4'((v / 100) % 10);
    b[7:4]   = 4'((v / 10) % 10);
    b[3:0]   = 4'(v % 10);
    return b;
  endfunction

  initial begin
    int n_done, t, t1, t2;
    tbl[0]  = '{16'h9999, 9999, 1'b0};
    tbl[1]  = '{16'h0000, 0,    1'b0};
    tbl[2]  = '{16'h1234, 1234, 1'b0};
    tbl[3]  = '{16'h1A00, 0,    1'b1};
    tbl[4]  = '{16'h0001, 1,    1'b0};
    tbl[5]  = '{16'h0010, 10,   1'b0};
    tbl[6]  = '{16'h5000, 5000, 1'b0};
    tbl[7]  = '{16'h0F00, 0,    1'b1};
    tbl[8]  = '{16'h9000, 9000, 1'b0};
    tbl[9]  = '{16'h0009, 9,    1'b0};
    tbl[10] = '{16'h999B, 0,    1'b1};
    tbl[11] = '{16'h4321, 4321, 1'b0};

    rst = 1'b1; start14 = 1'b0; start16 = 1'b0; dig14 = '0; dig16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy14, 0);
    chk("rst_done", done14, 0);
    chk("rst_error", err14, 0);
    chk("rst_output", out14, 0);
    chk("rst_output16", out16, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run14(tbl[i].bcd, tbl[i].exp_out, tbl[i].exp_err);

    // Error and Output hold through IDLE; next valid Start clears Error.
    run14(16'h1A00, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("error_hold", err14, 1);
    chk("output_hold_err", out14, 0);
    run14(16'h0007, 7, 1'b0);
    repeat (3) @(negedge clk);
    chk("output_hold", out14, 7);

    // Re-Start and digit change mid-SHIFT are ignored.
    @(negedge clk); dig14 = 16'h5000; start14 = 1'b1;
    @(negedge clk); start14 = 1'b0;
    repeat (3) @(negedge clk);
    start14 = 1'b1; dig14[3:0] = 4'h7;
    repeat (2) @(negedge clk);
    start14 = 1'b0; dig14 = 16'h0003;
    n_done = 0;
    repeat (3 * (W14 + 2)) begin
      if (done14) n_done++;
      @(negedge clk);
    end
    chk("midshift_single_done", n_done, 1);
    chk("midshift_output", out14, 5000);

    // Reset during SHIFT step 6 of 4321: abort, outputs cleared, no Done.
    @(negedge clk); dig14 = 16'h4321; start14 = 1'b1;
    @(negedge clk); start14 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", busy14, 0);
    chk("abort_done", done14, 0);
    chk("abort_output", out14, 0);
    n_done = 0;
    repeat (3 * (W14 + 2)) begin
      if (done14) n_done++;
      @(negedge clk);
    end
    chk("abort_no_done", n_done, 0);

    // Start held high: relaunch every W+2 cycles.
    @(negedge clk); dig14 = 16'h0042; start14 = 1'b1;
    t = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && t < 100) begin
      @(negedge clk); t++;
      if (done14) begin
        if (t1 < 0) t1 = t; else t2 = t;
      end
    end
    start14 = 1'b0;
    chk("held_start_seen", (t2 >= 0), 1);
    chk("held_start_period", t2 - t1, W14 + 2);
    chk("held_start_output", out14, 42);
    repeat (W14 + 4) @(negedge clk);

    // W=16 build.
    run16(16'h8188, 16'h1FFC, 1'b0);
    run16(16'h8192, 16'h2000, 1'b0);
    run16(16'h9999, 16'h270F, 1'b0);
    run16(16'hC000, 0, 1'b1);
    for (int v = 0; v <= 9999; v += 37) run16(to_bcd(v), v, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
